pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 94 +++++++++
 tb/tb_pipe_stage_skid.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: registered valid/ready handshake on both sides,
// plus a saturating counter of downstream back-pressure cycles.
//
// state | meaning
// EMPTY | nothing held, dn_valid=0, up_ready=1
// BUSY  | main_q valid, skid_q free
// FULL  | main_q and skid_q valid, upstream held off
module pipe_stage_skid #(
  parameter int PAYLOAD_W      = 64,
  parameter int CNT_W          = 16,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 up_ready,
  output logic                 dn_valid,
  output logic [PAYLOAD_W-1:0] dn_data,
  input  logic                 dn_ready,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic [CNT_W-1:0]     stall_cnt_q;

  // Outputs decode only from flops, so neither handshake side sees a combinational path.
  assign dn_valid  = (state_q != EMPTY);
  assign up_ready  = (state_q != FULL);
  assign dn_data   = main_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (flush) begin
      state_q <= EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (up_valid) begin
            main_q  <= up_data;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (up_valid && dn_ready) begin
            main_q <= up_data;
          end else if (up_valid) begin
            skid_q  <= up_data;
            state_q <= FULL;
          end else if (dn_ready) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // upstream is held off here, so up_valid is deliberately not looked at
          if (dn_ready) begin
            main_q  <= skid_q;
            state_q <= BUSY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Counts cycles the downstream refuses a valid payload; flush does not touch it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (dn_valid && !dn_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one instance clears on flush, a second holds payloads.
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic [7:0] up_data;
  logic       dn_ready;
  logic       flush;

  logic       a_up_ready, a_dn_valid;
  logic [7:0] a_dn_data;
  logic [3:0] a_stall_cnt;
  logic       b_up_ready, b_dn_valid;
  logic [7:0] b_dn_data;
  logic [3:0] b_stall_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.PAYLOAD_W(8), .CNT_W(4), .CLEAR_ON_FLUSH(1)) dut_a (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_ready(a_up_ready),
    .dn_valid(a_dn_valid), .dn_data(a_dn_data), .dn_ready(dn_ready), .flush(flush),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_skid #(.PAYLOAD_W(8), .CNT_W(4), .CLEAR_ON_FLUSH(0)) dut_b (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_ready(b_up_ready),
    .dn_valid(b_dn_valid), .dn_data(b_dn_data), .dn_ready(dn_ready), .flush(flush),
    .stall_cnt(b_stall_cnt)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; up_valid = 1'b0; up_data = 8'h00; dn_ready = 1'b0; flush = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_dn_valid !== 1'b0) $display("FAIL reset_dn_valid got %b exp 0", a_dn_valid); else passes++;
    checks++; if (a_up_ready !== 1'b1) $display("FAIL reset_up_ready got %b exp 1", a_up_ready); else passes++;
    checks++; if (a_stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt got %0d exp 0", a_stall_cnt); else passes++;
    checks++; if (a_dn_data !== 8'h00) $display("FAIL reset_dn_data got %h exp 00", a_dn_data); else passes++;
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = vals[i];
      cycle();
      checks++; if (a_dn_valid !== 1'b1 || a_dn_data !== vals[i])
        $display("FAIL stream_data[%0d] got v=%b d=%h exp v=1 d=%h", i, a_dn_valid, a_dn_data, vals[i]); else passes++;
      checks++; if (a_up_ready !== 1'b1) $display("FAIL stream_up_ready[%0d] got %b exp 1", i, a_up_ready); else passes++;
    end
    up_valid = 1'b0;
    cycle();
    checks++; if (a_dn_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", a_dn_valid); else passes++;
    checks++; if (a_stall_cnt !== 4'd0) $display("FAIL stream_stall_cnt got %0d exp 0", a_stall_cnt); else passes++;
  endtask

  task automatic test_skid();
    do_reset();
    up_valid = 1'b1; up_data = 8'hAA; dn_ready = 1'b0;
    cycle();
    checks++; if (a_dn_data !== 8'hAA || a_up_ready !== 1'b1)
      $display("FAIL skid_busy got d=%h r=%b exp d=aa r=1", a_dn_data, a_up_ready); else passes++;
    up_data = 8'hBB;
    cycle();
    checks++; if (a_up_ready !== 1'b0 || a_dn_data !== 8'hAA)
      $display("FAIL skid_full got r=%b d=%h exp r=0 d=aa", a_up_ready, a_dn_data); else passes++;
    up_data = 8'hCC;
    cycle();
    checks++; if (a_up_ready !== 1'b0 || a_dn_data !== 8'hAA || a_dn_valid !== 1'b1)
      $display("FAIL skid_ignore_up got r=%b d=%h v=%b exp r=0 d=aa v=1", a_up_ready, a_dn_data, a_dn_valid); else passes++;
    up_valid = 1'b0; dn_ready = 1'b1;
    cycle();
    checks++; if (a_dn_data !== 8'hBB || a_dn_valid !== 1'b1 || a_up_ready !== 1'b1)
      $display("FAIL skid_deliver_bb got d=%h v=%b r=%b exp d=bb v=1 r=1", a_dn_data, a_dn_valid, a_up_ready); else passes++;
    cycle();
    checks++; if (a_dn_valid !== 1'b0) $display("FAIL skid_empty got %b exp 0", a_dn_valid); else passes++;
    checks++; if (a_stall_cnt !== 4'd2) $display("FAIL skid_stall_cnt got %0d exp 2", a_stall_cnt); else passes++;
  endtask

  task automatic test_flush_full();
    do_reset();
    up_valid = 1'b1; up_data = 8'h01;
    cycle();
    up_data = 8'h02;
    cycle();
    checks++; if (a_up_ready !== 1'b0) $display("FAIL flush_pre_full got %b exp 0", a_up_ready); else passes++;
    flush = 1'b1; up_data = 8'h03;
    cycle();
    checks++; if (a_dn_valid !== 1'b0 || a_dn_data !== 8'h00 || a_up_ready !== 1'b1)
      $display("FAIL flush_full got v=%b d=%h r=%b exp v=0 d=00 r=1", a_dn_valid, a_dn_data, a_up_ready); else passes++;
    flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (a_dn_valid !== 1'b0 || a_dn_data === 8'h03)
        $display("FAIL flush_no_03[%0d] got v=%b d=%h exp v=0", i, a_dn_valid, a_dn_data); else passes++;
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    up_valid = 1'b1; up_data = 8'h5A;
    cycle();
    up_valid = 1'b0;
    repeat (14) cycle();
    checks++; if (a_stall_cnt !== 4'd14) $display("FAIL stall_14 got %0d exp 14", a_stall_cnt); else passes++;
    repeat (6) cycle();
    checks++; if (a_stall_cnt !== 4'd15) $display("FAIL stall_sat got %0d exp 15", a_stall_cnt); else passes++;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++; if (a_stall_cnt !== 4'd15 || a_dn_valid !== 1'b0)
      $display("FAIL stall_after_flush got c=%0d v=%b exp c=15 v=0", a_stall_cnt, a_dn_valid); else passes++;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    checks++; if (a_stall_cnt !== 4'd0) $display("FAIL stall_after_rst got %0d exp 0", a_stall_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    up_valid = 1'b1; up_data = 8'h61;
    cycle();
    up_data = 8'h62;
    cycle();
    rst = 1'b0; up_valid = 1'b0;
    cycle();
    rst = 1'b1;
    checks++; if (a_dn_valid !== 1'b0 || a_up_ready !== 1'b1)
      $display("FAIL rstmid_state got v=%b r=%b exp v=0 r=1", a_dn_valid, a_up_ready); else passes++;
    up_valid = 1'b1; up_data = 8'h55; dn_ready = 1'b1;
    cycle();
    up_valid = 1'b0;
    checks++; if (a_dn_valid !== 1'b1 || a_dn_data !== 8'h55)
      $display("FAIL rstmid_55 got v=%b d=%h exp v=1 d=55", a_dn_valid, a_dn_data); else passes++;
    cycle();
    checks++; if (a_dn_valid !== 1'b0) $display("FAIL rstmid_drain got %b exp 0", a_dn_valid); else passes++;
  endtask

  task automatic test_no_clear();
    do_reset();
    up_valid = 1'b1; up_data = 8'h77;
    cycle();
    up_valid = 1'b0;
    checks++; if (b_dn_valid !== 1'b1 || b_dn_data !== 8'h77)
      $display("FAIL noclr_busy got v=%b d=%h exp v=1 d=77", b_dn_valid, b_dn_data); else passes++;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++; if (b_dn_valid !== 1'b0 || b_dn_data !== 8'h77)
      $display("FAIL noclr_flush got v=%b d=%h exp v=0 d=77", b_dn_valid, b_dn_data); else passes++;
    checks++; if (a_dn_data !== 8'h00) $display("FAIL clr_flush got %h exp 00", a_dn_data); else passes++;
  endtask

  initial begin
    rst = 1'b0; up_valid = 1'b0; up_data = 8'h00; dn_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_stall_sat();
    test_reset_mid();
    test_no_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
